// File: rtl/jts16_ba0_arbiter.sv
// Bank-0 SDRAM scheduler: four requesters with one-word caches, round-robin over misses.
// Latency: cs to ok is 3 cycles plus controller ack/rdy delay on a miss; hits are combinational.
// Backpressure: a request holds address/data/rd/wr stable until sdram_ack, then waits for data_rdy.
module jts16_ba0_arbiter #(
    parameter int          AW0     = 15,
    parameter int          AW1     = 17,
    parameter int          AW2     = 14,
    parameter int          AW3     = 14,
    parameter logic [21:0] OFFSET0 = 22'h10_0000,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h10_0000,
    parameter logic [21:0] OFFSET3 = 22'h10_0000
) (
    input  logic           clk,
    input  logic           rst,

    input  logic [AW0-1:0] slot0_addr,
    input  logic           slot0_cs,
    input  logic           slot0_wen,
    input  logic [15:0]    slot0_din,
    input  logic [1:0]     slot0_wrmask,
    output logic           slot0_ok,
    output logic [15:0]    slot0_dout,

    input  logic [AW1-1:0] slot1_addr,
    input  logic           slot1_cs,
    output logic           slot1_ok,
    output logic [15:0]    slot1_dout,

    input  logic [AW2-1:0] slot2_addr,
    input  logic           slot2_cs,
    output logic           slot2_ok,
    output logic [15:0]    slot2_dout,

    input  logic [AW3-1:0] slot3_addr,
    input  logic           slot3_cs,
    output logic           slot3_ok,
    output logic [15:0]    slot3_dout,

    output logic [21:0]    sdram_addr,
    output logic           sdram_rd,
    output logic           sdram_wr,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [31:0]    data_read,
    output logic [15:0]    data_write,
    output logic [1:0]     sdram_wrmask
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Common tag width: every slot address is zero-extended to this.
    localparam int AWM = max2(max2(AW0, AW1), max2(AW2, AW3));

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    // Normalised per-slot views
    logic [AWM-1:0] addr_x [4];
    logic [21:0]    offs   [4];
    logic [3:0]     cs_x;

    assign addr_x[0] = AWM'(slot0_addr);
    assign addr_x[1] = AWM'(slot1_addr);
    assign addr_x[2] = AWM'(slot2_addr);
    assign addr_x[3] = AWM'(slot3_addr);
    assign offs[0]   = OFFSET0;
    assign offs[1]   = OFFSET1;
    assign offs[2]   = OFFSET2;
    assign offs[3]   = OFFSET3;
    assign cs_x      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};

    // Only the low half of the SDRAM bus carries data for this bank.
    logic unused_data_hi;
    assign unused_data_hi = ^data_read[31:16];

    // State
    logic [1:0]     state_q,      state_d;
    logic [1:0]     rr_q,         rr_d;
    logic [1:0]     slot_q,       slot_d;
    logic           is_wr_q,      is_wr_d;
    logic [AWM-1:0] lat_addr_q,   lat_addr_d;
    logic [21:0]    sdram_addr_q, sdram_addr_d;
    logic           rd_q,         rd_d;
    logic           wr_q,         wr_d;
    logic [15:0]    dwrite_q,     dwrite_d;
    logic [1:0]     wrmask_q,     wrmask_d;
    logic [AWM-1:0] tag_q  [4];
    logic [AWM-1:0] tag_d  [4];
    logic [15:0]    data_q [4];
    logic [15:0]    data_d [4];
    logic [3:0]     valid_q,      valid_d;
    logic           wd_q,         wd_d;
    logic [AWM-1:0] wd_addr_q,    wd_addr_d;

    logic       wr_finish;
    logic [3:0] inv_now;
    logic [3:0] hit;
    logic [3:0] pend;
    logic       wd_eff;
    logic       any_pend;
    logic [1:0] pick_sel;
    logic [1:0] pick_idx;

    // A write completing this cycle invalidates every entry aliasing the written SDRAM word;
    // the invalidation also masks that entry's hit in the same cycle so no stale data escapes.
    assign wr_finish = (state_q == ST_WAIT_RDY) && data_rdy && is_wr_q;

    // Per-slot hit, invalidation and pending decode
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            inv_now[n] = wr_finish && valid_q[n] &&
                         ((offs[n] + 22'(tag_q[n])) == sdram_addr_q);
            hit[n]     = cs_x[n] && valid_q[n] && (tag_q[n] == addr_x[n]) && !inv_now[n];
        end
        // A slot-0 write never hits the read cache.
        hit[0] = hit[0] && !slot0_wen;
        wd_eff = wd_q && slot0_cs && slot0_wen && (wd_addr_q == addr_x[0]);
        pend[0] = slot0_cs && (slot0_wen ? !wd_eff : !hit[0]);
        for (int n = 1; n < 4; n++) begin
            pend[n] = cs_x[n] && !hit[n];
        end
    end

    // Round-robin pick: first pending slot scanning from rr+1, rr itself last.
    always_comb begin
        any_pend = 1'b0;
        pick_sel = 2'd0;
        pick_idx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            pick_idx = rr_q + 2'(i);
            if (!any_pend && pend[pick_idx]) begin
                any_pend = 1'b1;
                pick_sel = pick_idx;
            end
        end
    end

    // Next-state logic for the scheduler FSM, cache and write-done flag
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        slot_d       = slot_q;
        is_wr_d      = is_wr_q;
        lat_addr_d   = lat_addr_q;
        sdram_addr_d = sdram_addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        dwrite_d     = dwrite_q;
        wrmask_d     = wrmask_q;
        tag_d        = tag_q;
        data_d       = data_q;
        valid_d      = valid_q;
        wd_addr_d    = wd_addr_q;
        // The done flag survives only while the same write request is still presented.
        wd_d         = wd_eff;

        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    slot_d       = pick_sel;
                    is_wr_d      = (pick_sel == 2'd0) && slot0_wen;
                    lat_addr_d   = addr_x[pick_sel];
                    sdram_addr_d = offs[pick_sel] + 22'(addr_x[pick_sel]);
                    if ((pick_sel == 2'd0) && slot0_wen) begin
                        dwrite_d = slot0_din;
                        wrmask_d = slot0_wrmask;
                        rd_d     = 1'b0;
                        wr_d     = 1'b1;
                    end else begin
                        wrmask_d = 2'b11;
                        rd_d     = 1'b1;
                        wr_d     = 1'b0;
                    end
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (data_rdy) begin
                    if (is_wr_q) begin
                        wd_d      = 1'b1;
                        wd_addr_d = lat_addr_q;
                        valid_d   = valid_q & ~inv_now;
                    end else begin
                        // Fill under the latched tag even if the requester moved on.
                        tag_d[slot_q]   = lat_addr_q;
                        data_d[slot_q]  = data_read[15:0];
                        valid_d[slot_q] = 1'b1;
                    end
                    rr_d    = slot_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= 2'd0;
            slot_q       <= 2'd0;
            is_wr_q      <= 1'b0;
            lat_addr_q   <= '0;
            sdram_addr_q <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            dwrite_q     <= '0;
            wrmask_q     <= '0;
            valid_q      <= '0;
            wd_q         <= 1'b0;
            wd_addr_q    <= '0;
            for (int n = 0; n < 4; n++) begin
                tag_q[n]  <= '0;
                data_q[n] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            slot_q       <= slot_d;
            is_wr_q      <= is_wr_d;
            lat_addr_q   <= lat_addr_d;
            sdram_addr_q <= sdram_addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            dwrite_q     <= dwrite_d;
            wrmask_q     <= wrmask_d;
            valid_q      <= valid_d;
            wd_q         <= wd_d;
            wd_addr_q    <= wd_addr_d;
            for (int n = 0; n < 4; n++) begin
                tag_q[n]  <= tag_d[n];
                data_q[n] <= data_d[n];
            end
        end
    end

    assign slot0_ok     = hit[0] || wd_eff;
    assign slot1_ok     = hit[1];
    assign slot2_ok     = hit[2];
    assign slot3_ok     = hit[3];
    assign slot0_dout   = data_q[0];
    assign slot1_dout   = data_q[1];
    assign slot2_dout   = data_q[2];
    assign slot3_dout   = data_q[3];
    assign sdram_addr   = sdram_addr_q;
    assign sdram_rd     = rd_q;
    assign sdram_wr     = wr_q;
    assign data_write   = dwrite_q;
    assign sdram_wrmask = wrmask_q;

endmodule

// File: tb/tb_jts16_ba0_arbiter.sv
// Directed bench for the bank-0 scheduler: reset, hits/misses, round robin, write invalidation.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that point too.
// The bench plays the SDRAM controller, answering each request with ack then data_rdy.
module tb_jts16_ba0_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] slot0_addr = '0;
    logic        slot0_cs = 1'b0, slot0_wen = 1'b0;
    logic [15:0] slot0_din = '0;
    logic [1:0]  slot0_wrmask = 2'b11;
    logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
    logic [15:0] slot0_dout, slot1_dout, slot2_dout, slot3_dout;
    logic [16:0] slot1_addr = '0;
    logic        slot1_cs = 1'b0;
    logic [13:0] slot2_addr = '0, slot3_addr = '0;
    logic        slot2_cs = 1'b0, slot3_cs = 1'b0;
    logic [21:0] sdram_addr;
    logic        sdram_rd, sdram_wr;
    logic        sdram_ack = 1'b0, data_rdy = 1'b0;
    logic [31:0] data_read = '0;
    logic [15:0] data_write;
    logic [1:0]  sdram_wrmask;

    int checks = 0;
    int errors = 0;

    jts16_ba0_arbiter dut (
        .clk(clk), .rst(rst),
        .slot0_addr(slot0_addr), .slot0_cs(slot0_cs), .slot0_wen(slot0_wen),
        .slot0_din(slot0_din), .slot0_wrmask(slot0_wrmask),
        .slot0_ok(slot0_ok), .slot0_dout(slot0_dout),
        .slot1_addr(slot1_addr), .slot1_cs(slot1_cs), .slot1_ok(slot1_ok), .slot1_dout(slot1_dout),
        .slot2_addr(slot2_addr), .slot2_cs(slot2_cs), .slot2_ok(slot2_ok), .slot2_dout(slot2_dout),
        .slot3_addr(slot3_addr), .slot3_cs(slot3_cs), .slot3_ok(slot3_ok), .slot3_dout(slot3_dout),
        .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
        .data_write(data_write), .sdram_wrmask(sdram_wrmask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, then check its kind and address.
    task automatic expect_req(input string tag, input bit is_wr, input logic [21:0] addr);
        int n = 0;
        while (!(sdram_rd || sdram_wr) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdwr"}, {30'd0, sdram_rd, sdram_wr}, is_wr ? 32'd1 : 32'd2);
        chk({tag, "_addr"}, {10'd0, sdram_addr}, {10'd0, addr});
    endtask

    task automatic do_ack();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic do_rdy(input logic [15:0] rdata);
        data_read = {16'hDEAD, rdata};
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        logic [21:0] a_hold;
        logic [15:0] d_hold;

        // Reset state
        #1;
        chk("rst_ok", {28'd0, slot3_ok, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
        chk("rst_rdwr", {30'd0, sdram_rd, sdram_wr}, 32'd0);
        chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
        chk("rst_mask", {30'd0, sdram_wrmask}, 32'd0);
        chk("rst_dout1", {16'd0, slot1_dout}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset during WAIT_RDY, then re-fetch
        slot1_addr = 17'h100;
        slot1_cs   = 1'b1;
        expect_req("r1", 1'b0, 22'h000100);
        do_ack();
        chk("r1_ackdrop", {31'd0, sdram_rd}, 32'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("r1_rst_ok", {31'd0, slot1_ok}, 32'd0);
        expect_req("r1_refetch", 1'b0, 22'h000100);
        chk("r1_noack_ok", {31'd0, slot1_ok}, 32'd0);
        do_ack();
        do_rdy(16'h1111);
        chk("r1_ok", {31'd0, slot1_ok}, 32'd1);
        chk("r1_dout", {16'd0, slot1_dout}, 32'h1111);

        // Slot 1 miss, hit and address change
        slot1_addr = 17'h1234;
        #1;
        chk("s1_miss_ok", {31'd0, slot1_ok}, 32'd0);
        expect_req("s1", 1'b0, 22'h001234);
        chk("s1_mask", {30'd0, sdram_wrmask}, 32'd3);
        do_ack();
        do_rdy(16'hBEEF);
        chk("s1_ok", {31'd0, slot1_ok}, 32'd1);
        chk("s1_dout", {16'd0, slot1_dout}, 32'hBEEF);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sdram_rd || sdram_wr) cnt++;
        end
        chk("s1_hold_noreq", cnt, 0);
        chk("s1_hold_ok", {31'd0, slot1_ok}, 32'd1);
        slot1_addr = 17'h1235;
        expect_req("s1b", 1'b0, 22'h001235);
        do_ack();
        do_rdy(16'hCAFE);
        chk("s1b_dout", {16'd0, slot1_dout}, 32'hCAFE);
        slot1_cs = 1'b0;

        // Simultaneous slot 2/3 misses with rr=1: slot 2 first, then slot 3, alternating
        slot2_addr = 14'h0040;
        slot3_addr = 14'h0080;
        slot2_cs   = 1'b1;
        slot3_cs   = 1'b1;
        expect_req("rr2", 1'b0, 22'h100040);
        do_ack();
        do_rdy(16'h2222);
        chk("rr2_ok", {31'd0, slot2_ok}, 32'd1);
        expect_req("rr3", 1'b0, 22'h100080);
        do_ack();
        do_rdy(16'h3333);
        chk("rr3_dout", {16'd0, slot3_dout}, 32'h3333);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            slot2_addr = 14'h0200 + 14'(k);
            slot3_addr = 14'h0300 + 14'(k);
            cnt = 0;
            while (!sdram_rd && cnt < 20) begin tick(); cnt++; end
            if (sdram_addr !== 22'h100200 + 22'(k)) bad++;
            do_ack();
            do_rdy(16'h0);
            cnt = 0;
            while (!sdram_rd && cnt < 20) begin tick(); cnt++; end
            if (sdram_addr !== 22'h100300 + 22'(k)) bad++;
            do_ack();
            do_rdy(16'h0);
        end
        chk("rr_alternate", bad, 0);
        slot3_cs   = 1'b0;
        slot2_addr = 14'h0040;
        expect_req("s2_refill", 1'b0, 22'h100040);
        do_ack();
        do_rdy(16'h4444);
        chk("s2_cached", {31'd0, slot2_ok}, 32'd1);

        // Slot 0 write aliasing slot 2's cached word
        slot0_addr   = 15'h0040;
        slot0_din    = 16'h55AA;
        slot0_wrmask = 2'b01;
        slot0_wen    = 1'b1;
        slot0_cs     = 1'b1;
        #1;
        chk("w_ok_before", {31'd0, slot0_ok}, 32'd0);
        expect_req("w", 1'b1, 22'h100040);
        chk("w_mask", {30'd0, sdram_wrmask}, 32'd1);
        chk("w_data", {16'd0, data_write}, 32'h55AA);
        do_ack();
        data_rdy = 1'b1;
        #1;
        chk("w_inv_same_cycle", {31'd0, slot2_ok}, 32'd0);
        tick();
        data_rdy = 1'b0;
        chk("w_ok", {31'd0, slot0_ok}, 32'd1);
        chk("w_s2_invalid", {31'd0, slot2_ok}, 32'd0);
        expect_req("s2_reissue", 1'b0, 22'h100040);
        do_ack();
        do_rdy(16'h55AA);
        chk("s2_reissue_dout", {16'd0, slot2_dout}, 32'h55AA);
        chk("s2_reissue_ok", {31'd0, slot2_ok}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sdram_wr) cnt++;
            if (!slot0_ok) cnt++;
        end
        chk("w_single_issue", cnt, 0);
        slot0_cs = 1'b0;
        #1;
        chk("w_ok_drop", {31'd0, slot0_ok}, 32'd0);
        tick();
        chk("w_no_reissue", {31'd0, sdram_wr}, 32'd0);
        slot2_cs = 1'b0;

        // Controller delays ack for 10 cycles: request must hold steady
        slot0_addr   = 15'h0010;
        slot0_din    = 16'hA5A5;
        slot0_wrmask = 2'b10;
        slot0_cs     = 1'b1;
        expect_req("dly", 1'b1, 22'h100010);
        a_hold = sdram_addr;
        d_hold = data_write;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!sdram_wr || sdram_rd || sdram_addr !== a_hold ||
                data_write !== d_hold || sdram_wrmask !== 2'b10) bad++;
        end
        chk("dly_stable", bad, 0);
        chk("dly_data", {16'd0, data_write}, 32'hA5A5);
        do_ack();
        chk("dly_ackdrop", {31'd0, sdram_wr}, 32'd0);
        do_rdy(16'h0);
        chk("dly_ok", {31'd0, slot0_ok}, 32'd1);
        slot0_cs  = 1'b0;
        slot0_wen = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
